reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_pkg.sv | 14 +
 rtl/reg_write_arbiter_rr_pick.sv | 27 ++
 rtl/reg_write_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the register write arbiter.
package reg_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 8;
  localparam int W_DEF    = 16;
  localparam int AW       = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of elig at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  choice,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    choice = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!valid && elig[idx]) begin
        choice[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates NREQ write requesters onto one shared register write port (latency 1).
// Define REG_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int W    = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*W-1:0]    req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREG-1:0]      reg_en,
  output logic [W-1:0]         reg_d,
  output logic                 addr_err,
  output logic                 busy
);

  localparam int PW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREG-1:0] reg_en_q, reg_en_d;
  logic [W-1:0]    reg_d_q, reg_d_d;
  logic            addr_err_q, addr_err_d;

  logic [NREQ-1:0] elig, pick_oh;
  logic            pick_vld;
  logic [PW-1:0]   ptr_pick;
  logic [AW-1:0]   sel_addr;
  logic [W-1:0]    sel_data;

  // A requester whose grant is on the bus this cycle sits out one decision.
  assign elig = req & ~gnt_q;

`ifdef REG_ARB_FIXED_PRIO_EN
  assign ptr_pick = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;

  assign ptr_pick = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .elig   (elig),
    .ptr    (ptr_pick),
    .choice (pick_oh),
    .valid  (pick_vld)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr = req_addr[AW*i +: AW];
        sel_data = req_data[W*i +: W];
      end
    end

    state_d = pick_vld ? GRANT : IDLE;
    gnt_d   = pick_vld ? pick_oh : '0;

    reg_en_d = '0;
    for (int r = 0; r < NREG; r++) begin
      reg_en_d[r] = pick_vld && (int'(sel_addr) == r);
    end
    addr_err_d = pick_vld && (int'(sel_addr) >= NREG);
    reg_d_d    = pick_vld ? sel_data : reg_d_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      reg_en_q   <= '0;
      reg_d_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      reg_en_q   <= reg_en_d;
      reg_d_q    <= reg_d_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign gnt      = gnt_q;
  assign reg_en   = reg_en_q;
  assign reg_d    = reg_d_q;
  assign addr_err = addr_err_q;
  assign busy     = (state_q == GRANT);

endmodule
